// File: rtl/tt3_self_test_if.sv
// Stimulus/check bus between the tt3 self-test engine and its controller and block under test.
// The engine connects as master; the controller/bench side connects as slave.
interface tt3_self_test_if #(
  parameter int ERR_W = 4
) ();
  logic             start;
  logic             abort;
  logic             y_in;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [2:0]       fail_idx;
  logic             fail_valid;

  modport master (
    input  start, abort, y_in,
    output a, b, c, busy, done, pass, err_count, fail_idx, fail_valid
  );

  modport slave (
    output start, abort, y_in,
    input  a, b, c, busy, done, pass, err_count, fail_idx, fail_valid
  );
endinterface

// File: rtl/tt3_self_test.sv
// Exhaustive self-test engine for a 3-input/1-output combinational block.
// Optional macro STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module tt3_self_test #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h17,
  parameter int          ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tt3_self_test_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       settle_q, settle_d;
  logic [2:0]       abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       fail_idx_q, fail_idx_d;
  logic             fail_valid_q, fail_valid_d;
  logic             mismatch;
  logic             last_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      settle_q     <= '0;
      abc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_idx_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      abc_q        <= abc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_idx_q   <= fail_idx_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    abc_d        = abc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_idx_d   = fail_idx_q;
    fail_valid_d = fail_valid_q;
    mismatch     = 1'b0;
    last_vec     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        abc_d  = '0;
        if (bus.start && !bus.abort) begin
          state_d      = S_WAIT;
          idx_d        = '0;
          settle_d     = SETTLE_INIT;
          err_d        = '0;
          pass_d       = 1'b0;
          fail_idx_d   = '0;
          fail_valid_d = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          abc_d   = '0;
          pass_d  = 1'b0;
        end else if (settle_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end

      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          abc_d   = '0;
          pass_d  = 1'b0;
        end else begin
          mismatch = (bus.y_in != EXPECTED[idx_q]);
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            if (!fail_valid_q) begin
              fail_idx_d   = idx_q;
              fail_valid_d = 1'b1;
            end
          end
`ifdef STOP_ON_FAIL_EN
          last_vec = (idx_q == 3'd7) || mismatch;
`else
          last_vec = (idx_q == 3'd7);
`endif
          if (last_vec) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            abc_d   = '0;
            // Uses the post-compare count so the final vector is included.
            pass_d  = (err_d == '0);
          end else begin
            state_d  = S_WAIT;
            idx_d    = idx_q + 3'd1;
            abc_d    = idx_q + 3'd1;
            settle_d = SETTLE_INIT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        abc_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        abc_d   = '0;
      end
    endcase
  end

  assign bus.a          = abc_q[2];
  assign bus.b          = abc_q[1];
  assign bus.c          = abc_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_idx   = fail_idx_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_tt3_self_test.sv
// Scoreboard bench for tt3_self_test: a behavioural block model feeds y_in,
// expected run results are queued at start and checked on the done pulse.
module tb_tt3_self_test;

  localparam int S  = 2;
  localparam int VP = S + 1;

  typedef struct {
    int done_edge;
    int err;
    bit pass;
    int fidx;
    bit fv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  tt3_self_test_if #(.ERR_W(4)) bus ();

  tt3_self_test #(
    .SETTLE_CYCLES(S),
    .EXPECTED(8'h17),
    .ERR_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int ones3(logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  // 0: correct minority, 1: majority, 2: minority with y stuck 1 at abc=101
  function automatic logic blk(int m, logic [2:0] v);
    if (m == 1) return ones3(v) >= 2;
    if (m == 2 && v == 3'b101) return 1'b1;
    return ones3(v) <= 1;
  endfunction

  assign bus.y_in = blk(mode, {bus.a, bus.b, bus.c});

  // Result of a run whose compares happen at edges (v+1)*VP, counting only those before cut.
  function automatic exp_t predict(int m, int cut);
    exp_t r;
    r.done_edge = 8 * VP;
    r.err = 0;
    r.fidx = 0;
    r.fv = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if ((v + 1) * VP >= cut) break;
      if (blk(m, 3'(v)) != (ones3(3'(v)) <= 1)) begin
        if (r.err < 15) r.err++;
        if (!r.fv) begin
          r.fidx = v;
          r.fv = 1'b1;
        end
`ifdef STOP_ON_FAIL_EN
        r.done_edge = (v + 1) * VP;
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_abc"}, 32'({bus.a, bus.b, bus.c}), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  // Start a run in mode m; optionally abort at edge abort_e or re-pulse start at restart_e.
  task automatic run(input int m, input int abort_e, input int restart_e);
    exp_t cur;
    exp_t got_r;
    bit   seen;
    int   limit;
    mode = m;
    seen = 1'b0;
    bus.start = 1'b1;
    if (abort_e < 0) begin
      sb_q.push_back(predict(m, 1000));
      cur = sb_q[0];
      limit = cur.done_edge;
    end else begin
      cur = predict(m, abort_e);
      limit = abort_e + 4;
    end
    for (int e = 0; e <= limit && !seen; e++) begin
      @(posedge clk);
      #1;
      bus.start = (restart_e >= 0 && e + 1 == restart_e);
      bus.abort = (abort_e >= 0 && e + 1 == abort_e);
      if (abort_e >= 0 && e >= abort_e) begin
        check_idle_outputs("abort");
        if (e == limit) begin
          check("abort_pass", 32'(bus.pass), 32'd0);
          check("abort_err", 32'(bus.err_count), 32'(cur.err));
          check("abort_fv", 32'(bus.fail_valid), 32'(cur.fv));
          check("abort_fidx", 32'(bus.fail_idx), 32'(cur.fidx));
          $display("txn mode=%0d aborted@%0d err=%0d fv=%0d", m, abort_e, bus.err_count, bus.fail_valid);
          seen = 1'b1;
        end
      end else if (e < cur.done_edge) begin
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_done", 32'(bus.done), 32'd0);
        check("run_abc", 32'({bus.a, bus.b, bus.c}), 32'(e / VP));
      end else begin
        got_r = sb_q.pop_front();
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
        check("done_err", 32'(bus.err_count), 32'(got_r.err));
        check("done_pass", 32'(bus.pass), 32'(got_r.pass));
        check("done_fv", 32'(bus.fail_valid), 32'(got_r.fv));
        check("done_fidx", 32'(bus.fail_idx), 32'(got_r.fidx));
        $display("txn mode=%0d done@%0d err=%0d pass=%0d fidx=%0d fv=%0d", m, e,
                 bus.err_count, bus.pass, bus.fail_idx, bus.fail_valid);
        seen = 1'b1;
      end
    end
    if (!seen) check("run_timeout", 32'd0, 32'd1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("post_run");
  endtask

  initial begin
    int abort_mode;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef STOP_ON_FAIL_EN
    abort_mode = 0;
`else
    abort_mode = 1;
`endif

    #1;
    check_idle_outputs("reset");
    check("reset_err", 32'(bus.err_count), 32'd0);
    check("reset_pass", 32'(bus.pass), 32'd0);
    check("reset_fv", 32'(bus.fail_valid), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_idle_outputs("post_reset");
    $display("txn reset released");

    run(0, -1, -1);
    run(1, -1, -1);
    run(2, -1, -1);
    run(abort_mode, 10, -1);
    run(0, -1, -1);
    run(0, -1, 5);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_idle_outputs("start_abort_idle");
    end
    check("start_abort_pass_kept", 32'(bus.pass), 32'd1);
    $display("txn start+abort in idle ignored");

    mode = 1;
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_err", 32'(bus.err_count), 32'd0);
    check("async_reset_fv", 32'(bus.fail_valid), 32'd0);
    check("async_reset_fidx", 32'(bus.fail_idx), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_idle_outputs("after_async_reset");
    end
    $display("txn async reset mid-run");

    run(0, -1, -1);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
